// File: rtl/arb_pkg.sv
// Shared types and default geometry for the memory-port arbiter.
package arb_pkg;

   localparam int DEF_LINE_BEATS = 4;
   localparam int DEF_BEAT_BYTES = 8;
   localparam int LINE_BYTES     = DEF_LINE_BEATS * DEF_BEAT_BYTES;
   localparam int OFFSET_W       = $clog2(LINE_BYTES);
   localparam int CNT_W          = $clog2(DEF_LINE_BEATS) + 1;

   typedef enum logic [2:0] {
      IDLE,
      IC_XFER,
      DC_RD,
      DC_WR,
      DC_WDONE
   } arb_state_e;

   typedef enum logic {
      OWN_IC,
      OWN_DC
   } owner_e;

endpackage

// File: rtl/arb_beat_counter.sv
// Issue/return beat counter pair for one requester.
// Cleared while the arbiter is idle; reports the returning beat that completes the target.
module arb_beat_counter
   import arb_pkg::*;
#(
   parameter int CW = CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          issue_i,
   input  logic          ret_i,
   input  logic [CW-1:0] target_i,
   output logic [CW-1:0] issue_cnt_o,
   output logic          issue_done_o,
   output logic          last_ret_o
);

   logic [CW-1:0] issue_cnt_q, issue_cnt_d;
   logic [CW-1:0] ret_cnt_q, ret_cnt_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      if (clr_i) begin
         issue_cnt_d = '0;
         ret_cnt_d   = '0;
      end else begin
         if (issue_i) issue_cnt_d = issue_cnt_q + CW'(1);
         if (ret_i)   ret_cnt_d   = ret_cnt_q + CW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   assign issue_cnt_o  = issue_cnt_q;
   assign issue_done_o = (issue_cnt_q == target_i);
   assign last_ret_o   = ret_i && (ret_cnt_q == target_i - CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between IC line refills and DC single-beat accesses.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int LINE_BEATS     = DEF_LINE_BEATS,
   parameter int BEAT_BYTES     = DEF_BEAT_BYTES,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IC_REQ,
   input  logic [63:0] IC_ADDR,
   output logic        IC_GNT,
   output logic        IC_RVALID,
   output logic [63:0] IC_RDATA,
   output logic        IC_DONE,
   output logic        IC_ERR,
   input  logic        DC_REQ,
   input  logic        DC_WE,
   input  logic [63:0] DC_ADDR,
   input  logic [63:0] DC_WDATA,
   input  logic [7:0]  DC_WSTRB,
   output logic        DC_GNT,
   output logic        DC_RVALID,
   output logic [63:0] DC_RDATA,
   output logic        DC_DONE,
   output logic        DC_ERR,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [63:0] MEM_ADDR,
   output logic [63:0] MEM_WDATA,
   output logic [7:0]  MEM_WSTRB,
   input  logic        MEM_READY,
   input  logic        MEM_RVALID,
   input  logic [63:0] MEM_RDATA,
   output logic        ARB_BUSY
);

   localparam int            CW        = $clog2(LINE_BEATS) + 1;
   localparam logic [CW-1:0] IC_TARGET = CW'(LINE_BEATS);
   localparam logic [CW-1:0] DC_TARGET = CW'(1);
   localparam logic [63:0]   LINE_MASK = 64'(LINE_BEATS * BEAT_BYTES) - 64'd1;

   arb_state_e  state_q, state_d;
   owner_e      last_winner_q, last_winner_d;
   logic        ic_gnt_q, ic_gnt_d, dc_gnt_q, dc_gnt_d;
   logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [7:0]  wstrb_q, wstrb_d;

   logic          mem_req, accept, progress, abort;
   logic          in_ic, in_dc, idle;
   logic          ic_win, dc_win;
   logic [CW-1:0] ic_issue_cnt, dc_issue_cnt;
   logic          ic_issue_done, dc_issue_done, ic_last, dc_last;

   assign idle  = (state_q == IDLE);
   assign in_ic = (state_q == IC_XFER);
   assign in_dc = (state_q == DC_RD) || (state_q == DC_WR) || (state_q == DC_WDONE);

   // On contention the requester that did not win last time gets the port.
   assign ic_win = IC_REQ && (!DC_REQ || last_winner_q == OWN_DC);
   assign dc_win = DC_REQ && (!IC_REQ || last_winner_q == OWN_IC);

   always_comb begin
      unique case (state_q)
         IC_XFER: mem_req = !ic_issue_done;
         DC_RD:   mem_req = !dc_issue_done;
         DC_WR:   mem_req = 1'b1;
         default: mem_req = 1'b0;
      endcase
   end

   assign accept   = mem_req && MEM_READY;
   assign progress = accept || (MEM_RVALID && (in_ic || state_q == DC_RD));

   arb_beat_counter #(.CW(CW)) u_ic_cnt (
      .clk          (CLK),
      .rst          (RESET),
      .clr_i        (idle),
      .issue_i      (in_ic && accept),
      .ret_i        (in_ic && MEM_RVALID),
      .target_i     (IC_TARGET),
      .issue_cnt_o  (ic_issue_cnt),
      .issue_done_o (ic_issue_done),
      .last_ret_o   (ic_last)
   );

   arb_beat_counter #(.CW(CW)) u_dc_cnt (
      .clk          (CLK),
      .rst          (RESET),
      .clr_i        (idle),
      .issue_i      (state_q == DC_RD && accept),
      .ret_i        (state_q == DC_RD && MEM_RVALID),
      .target_i     (DC_TARGET),
      .issue_cnt_o  (dc_issue_cnt),
      .issue_done_o (dc_issue_done),
      .last_ret_o   (dc_last)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;

   always_comb begin
      abort  = !idle && !progress && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
      wdog_d = (idle || progress || abort) ? '0 : wdog_q + WD_W'(1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      last_winner_d = last_winner_q;
      ic_gnt_d      = 1'b0;
      dc_gnt_d      = 1'b0;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      unique case (state_q)
         IDLE: begin
            if (ic_win) begin
               state_d       = IC_XFER;
               ic_gnt_d      = 1'b1;
               last_winner_d = OWN_IC;
               addr_d        = IC_ADDR & ~LINE_MASK;
               we_d          = 1'b0;
               wdata_d       = '0;
               wstrb_d       = '0;
            end else if (dc_win) begin
               state_d       = DC_WE ? DC_WR : DC_RD;
               dc_gnt_d      = 1'b1;
               last_winner_d = OWN_DC;
               addr_d        = DC_ADDR;
               we_d          = DC_WE;
               wdata_d       = DC_WDATA;
               wstrb_d       = DC_WSTRB;
            end
         end
         IC_XFER:  if (ic_last) state_d = IDLE;
         DC_RD:    if (dc_last) state_d = IDLE;
         DC_WR:    if (accept)  state_d = DC_WDONE;
         DC_WDONE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q       <= IDLE;
         last_winner_q <= OWN_IC;
         ic_gnt_q      <= 1'b0;
         dc_gnt_q      <= 1'b0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
      end else begin
         state_q       <= state_d;
         last_winner_q <= last_winner_d;
         ic_gnt_q      <= ic_gnt_d;
         dc_gnt_q      <= dc_gnt_d;
         addr_q        <= addr_d;
         we_q          <= we_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
      end
   end

   // Beat fields come only from registers and the issue count, so they hold while stalled.
   assign MEM_REQ   = mem_req;
   assign MEM_WE    = mem_req && we_q;
   assign MEM_ADDR  = mem_req ? addr_q + 64'(in_ic ? ic_issue_cnt : dc_issue_cnt) * 64'(BEAT_BYTES) : '0;
   assign MEM_WDATA = mem_req ? wdata_q : '0;
   assign MEM_WSTRB = mem_req ? wstrb_q : '0;

   assign IC_GNT    = ic_gnt_q;
   assign IC_RVALID = in_ic && MEM_RVALID;
   assign IC_RDATA  = IC_RVALID ? MEM_RDATA : '0;
   assign IC_DONE   = ic_last || (abort && in_ic);
   assign IC_ERR    = abort && in_ic;

   assign DC_GNT    = dc_gnt_q;
   assign DC_RVALID = (state_q == DC_RD) && MEM_RVALID;
   assign DC_RDATA  = DC_RVALID ? MEM_RDATA : '0;
   assign DC_DONE   = dc_last || (state_q == DC_WDONE) || (abort && in_dc);
   assign DC_ERR    = abort && in_dc;

   assign ARB_BUSY  = !idle;

   a_ic_req_held: assert property (@(posedge CLK) disable iff (RESET) in_ic |-> IC_REQ);
   a_dc_req_held: assert property (@(posedge CLK) disable iff (RESET) in_dc |-> DC_REQ);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache refill path (fetch) and the data-cache/MEM-stage path.
- Sequences each IC line refill as LINE_BEATS pipelined read beats and each DC access as one read or write beat.
- Steers returning data to the owning requester.
- Sits between instruction_cache, the MEM-stage cache and the memory model/controller.

Parameters:
- LINE_BEATS, 4, beats per IC refill; power of two, ≥2.
- BEAT_BYTES, 8, bytes per beat (64-bit data); address stride per beat.
- TIMEOUT_CYCLES, 1023, response watchdog limit (optional feature only).

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- IC_REQ  in  1  IC line-read request; held until IC_DONE
- IC_ADDR  in  64  refill address; low log2(LINE_BEATS*BEAT_BYTES) bits ignored (line-aligned)
- IC_GNT  out  1  one-cycle pulse: IC owns port, address latched
- IC_RVALID  out  1  beat valid to IC
- IC_RDATA  out  64  beat data to IC
- IC_DONE  out  1  last beat / end of transaction
- IC_ERR  out  1  transaction aborted (timeout)
- DC_REQ  in  1  DC request; held until DC_DONE
- DC_WE  in  1  1 = write, 0 = read
- DC_ADDR  in  64  beat address (BEAT_BYTES-aligned)
- DC_WDATA  in  64  write data
- DC_WSTRB  in  8  byte enables
- DC_GNT / DC_RVALID / DC_RDATA[63:0] / DC_DONE / DC_ERR  out  as IC equivalents
- MEM_REQ  out  1  beat request valid
- MEM_WE  out  1  beat is write
- MEM_ADDR  out  64  beat address
- MEM_WDATA  out  64  write data
- MEM_WSTRB  out  8  byte enables
- MEM_READY  in  1  memory accepts beat when MEM_REQ && MEM_READY
- MEM_RVALID  in  1  read beat returned; in order, ≥1 cycle after accept
- MEM_RDATA  in  64  read data
- ARB_BUSY  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, counters=0, last_winner=IC; every output 0.
- Reset mid-transaction abandons it; in-flight MEM_RVALID after reset is dropped (memory shares RESET).
- States: IDLE, IC_XFER, DC_RD, DC_WR, DC_WDONE.

Arbitration (IDLE only):
- Exactly one requester: it wins.
- Both requesting: the one ≠ last_winner wins, so the first contention after reset goes to DC.
- On a win: assert GNT for 1 cycle, latch address/WE/WDATA/WSTRB, update last_winner, enter the transfer state next cycle.
- GNT is registered: high in the first cycle of the transfer state.

IC_XFER:
- MEM_REQ=1 while issue_cnt<LINE_BEATS.
- MEM_ADDR = line_base + issue_cnt*BEAT_BYTES.
- issue_cnt increments on each accept; issue and return overlap.
- IC_RVALID=MEM_RVALID and IC_RDATA=MEM_RDATA, combinational pass-through.
- ret_cnt increments per RVALID.
- IC_DONE is asserted in the same cycle as the RVALID that makes ret_cnt reach LINE_BEATS; next state IDLE.

DC_RD:
- One beat; MEM_REQ until accept.
- DC_RVALID/DC_RDATA pass through.
- DC_DONE is asserted with that RVALID; then IDLE.

DC_WR:
- MEM_REQ=MEM_WE=1 until accept, then DC_WDONE.
- DC_WDONE: DC_DONE=1 for one cycle, then IDLE.

Cross-cutting rules:
- MEM_RVALID while not owned (IDLE, DC_WR, DC_WDONE) is ignored; no RVALID is forwarded.
- The requester deasserts REQ the cycle after DONE. REQ seen in IDLE is always a new request, and DONE→IDLE→GNT takes ≥1 idle cycle.
- MEM_REQ/MEM_ADDR/MEM_WE/MEM_WDATA/MEM_WSTRB are stable while MEM_REQ && !MEM_READY.
- A request dropped before DONE is a protocol violation; behaviour is undefined and flagged by an assertion.
- Counters are log2(LINE_BEATS)+1 bits wide and never wrap within a transaction.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in any non-IDLE state with no MEM_READY accept or MEM_RVALID progress.
  - At TIMEOUT_CYCLES the transaction aborts: owner's ERR=1 and DONE=1 together for one cycle, then IDLE.
  - Watchdog resets on each progress event.
  - IC_ERR feeds the fetch access-fault path.
- Undefined: no watchdog; IC_ERR and DC_ERR are tied 0.

Decomposition:
- Package arb_pkg holds:
  - state enum (IDLE, IC_XFER, DC_RD, DC_WR, DC_WDONE);
  - owner enum (OWN_IC, OWN_DC);
  - localparams: LINE_BYTES, OFFSET_W, CNT_W.
- One natural sub-module, arb_beat_counter: issue/return counter pair with done compare, reused for IC and DC.

Test Plan:
- IC-only refill, IC_ADDR=0x1234, MEM_READY=1, RVALID 2 cycles after accept:
  - MEM_ADDR sequence 0x1220, 0x1228, 0x1230, 0x1238;
  - 4 IC_RVALID beats;
  - IC_DONE on the 4th; ARB_BUSY low the next cycle.
- IC_REQ and DC_REQ rise in the same cycle after reset:
  - DC granted first (read 0x80, data 0xDEAD);
  - then IC granted;
  - on the next simultaneous request, DC wins again (alternation).
- DC write 0x40, WDATA=0x1122334455667788, WSTRB=0x0F, MEM_READY low 3 cycles:
  - MEM_* held stable;
  - DC_DONE exactly 1 cycle after accept;
  - no RVALID forwarded.
- Spurious MEM_RVALID in IDLE and during DC_WR:
  - IC_RVALID=DC_RVALID=0;
  - counters unchanged.
- RESET asserted asynchronously after beat 2 of an IC refill:
  - all outputs 0 immediately;
  - state IDLE;
  - a fresh DC read then completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, IC refill with no RVALID after beat 1:
  - IC_ERR=IC_DONE=1 at cycle 16 with no progress;
  - next cycle IDLE.
